// File: rtl/jt12_ch_wr_if.sv
// jt12_ch_wr_if: CPU write/read port of the YM2612 channel register front end.
// The CPU side is the master; the register block is the slave.
interface jt12_ch_wr_if;
    logic       cs_n;
    logic       wr_n;
    logic [1:0] addr;
    logic [7:0] din;
    logic [7:0] dout;
    modport master(output cs_n, wr_n, addr, din, input dout);
    modport slave(input cs_n, wr_n, addr, din, output dout);
endinterface

// File: rtl/jt12_ch_wr.sv
// jt12_ch_wr: decodes CPU writes to channel registers A0-A6/B0-B6 into cen-aligned
// update strobes and drives the busy flag seen on status reads.
module jt12_ch_wr #(
    parameter int NUM_CH   = 6,
    parameter int BUSY_CYC = 32
) (
    input  logic         rst,
    input  logic         clk,
    input  logic         cen,
    jt12_ch_wr_if.slave  bus,
    output logic [7:0]   ch_din,
    output logic [2:0]   up_ch,
    output logic [5:0]   latch_fnum,
    output logic         up_fnumlo,
    output logic         up_alg,
    output logic         up_pms
);
    localparam int CW = $clog2(BUSY_CYC + 1);
    typedef enum logic [1:0] {K_NONE, K_FNUM, K_ALG, K_PMS} kind_t;
    logic          wr_last, wr_ok, accept, addr_wr, data_wr, ch_ok, fnum_hi, issue, busy, part;
    logic [7:0]    reg_addr, pend_din;
    logic [2:0]    pend_ch;
    logic [CW-1:0] cnt;
    kind_t         dec_kind, pend_kind;
    always_comb begin
        wr_ok    = !bus.cs_n && !bus.wr_n;
        accept   = wr_ok && !wr_last;
        addr_wr  = accept && !bus.addr[0];
        data_wr  = accept && bus.addr[0];
        ch_ok    = reg_addr[1:0] != 2'd3 && !(part && NUM_CH == 3);
        dec_kind = !ch_ok                  ? K_NONE :
                   reg_addr[7:2] == 6'h28  ? K_FNUM :
                   reg_addr[7:2] == 6'h2C  ? K_ALG  :
                   reg_addr[7:2] == 6'h2D  ? K_PMS  : K_NONE;
        fnum_hi  = ch_ok && reg_addr[7:2] == 6'h29;
        issue    = cen && pend_kind != K_NONE;
        bus.dout = {busy, 7'd0};
    end
    // A write landing on the issue edge refills the buffer after it is drained.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_last    <= 1'b0;
            reg_addr   <= 8'd0;
            part       <= 1'b0;
            latch_fnum <= 6'd0;
            up_ch      <= 3'd0;
            ch_din     <= 8'd0;
            up_fnumlo  <= 1'b0;
            up_alg     <= 1'b0;
            up_pms     <= 1'b0;
            pend_kind  <= K_NONE;
            pend_ch    <= 3'd0;
            pend_din   <= 8'd0;
            busy       <= 1'b0;
            cnt        <= '0;
        end else begin
            wr_last   <= wr_ok;
            up_fnumlo <= issue && pend_kind == K_FNUM;
            up_alg    <= issue && pend_kind == K_ALG;
            up_pms    <= issue && pend_kind == K_PMS;
            if (issue) begin
                up_ch     <= pend_ch;
                ch_din    <= pend_din;
                pend_kind <= K_NONE;
            end
            if (addr_wr) begin
                reg_addr <= bus.din;
                part     <= bus.addr[1];
            end
            if (data_wr && dec_kind != K_NONE) begin
                pend_kind <= dec_kind;
                pend_ch   <= {part, reg_addr[1:0]};
                pend_din  <= bus.din;
            end
            if (data_wr && fnum_hi)
                latch_fnum <= bus.din[5:0];
            if (data_wr) begin
                busy <= 1'b1;
                cnt  <= CW'(BUSY_CYC);
            end else if (cen && cnt != '0) begin
                cnt  <= cnt - 1'b1;
                busy <= cnt != CW'(1);
            end
        end
    end
endmodule

// File: doc/jt12_ch_wr.md
JT12_CH_WR -- requirements
Module: jt12_ch_wr

Interface
- REQ-001: Parameter NUM_CH, default 6, number of FM channels (6 or 3); when 3, part-2 channel accesses are ignored.
- REQ-002: Parameter BUSY_CYC, default 32, number of cen ticks the busy flag stays set after a data write.
- REQ-003: rst  input  1  reset, asynchronous, active-high.
- REQ-004: clk  input  1  clock.
- REQ-005: cen  input  1  clock enable; strobe issue and busy countdown advance only on cen=1 cycles.
- REQ-006: cs_n  input  1  CPU chip select, active-low.
- REQ-007: wr_n  input  1  CPU write strobe, active-low.
- REQ-008: addr  input  2  CPU port: bit0 0=address / 1=data, bit1 selects part (0: ch 0-2, 1: ch 3-5).
- REQ-009: din  input  8  CPU write data.
- REQ-010: dout  output  8  status read: {busy, 7'b0}.
- REQ-011: ch_din  output  8  data byte delivered alongside channel update strobes.
- REQ-012: up_ch  output  3  target channel: {part, reg_addr[1:0]}.
- REQ-013: latch_fnum  output  6  held {block, fnum[10:8]} from last A4-A6 data write.
- REQ-014: up_fnumlo  output  1  one-clk strobe, reg A0-A2 written.
- REQ-015: up_alg  output  1  one-clk strobe, reg B0-B2 written.
- REQ-016: up_pms  output  1  one-clk strobe, reg B4-B6 written.

Function
- REQ-017: A CPU write SHALL be accepted on the first clk rising edge where cs_n=0 and wr_n=0 after a cycle where that condition was false; a held strobe SHALL count as one write.
- REQ-018: An address write (addr[0]=0) SHALL latch reg_addr=din and part=addr[1]; it SHALL issue no strobe and not affect busy.
- REQ-019: A data write (addr[0]=1) SHALL decode reg_addr/part: A0-A2 -> pending up_fnumlo; A4-A6 -> latch_fnum<=din[5:0] immediately, no strobe; B0-B2 -> pending up_alg; B4-B6 -> pending up_pms; any other address, reg_addr[1:0]=3, or part=1 with NUM_CH=3 -> no action.
- REQ-020: A data write to part 1 SHALL require the preceding address write to have had addr[1]=1; part is taken from the last address write, not from the data write's addr[1].
- REQ-021: Pending update SHALL be held in a one-entry buffer {kind, up_ch, ch_din}; a new decoded data write before issue SHALL overwrite it (last write wins).
- REQ-022: The pending strobe SHALL assert for exactly one clk cycle, on the first cycle with cen=1 that is at least one clk after acceptance; up_ch and ch_din SHALL be stable in that cycle and hold until the next issue.
- REQ-023: At most one of up_fnumlo/up_alg/up_pms SHALL be high in any cycle.
- REQ-024: Every data write (decoded or not) SHALL set busy and load the counter with BUSY_CYC; counter decrements on each cen=1 cycle; busy clears when it reaches 0; a data write while busy reloads it.
- REQ-025: A write accepted in the same cycle as a strobe issue SHALL be buffered for the next cen cycle and SHALL NOT corrupt the strobe being issued.
- REQ-026: dout SHALL be combinational from the busy register; reads have no side effect.

Reset
- REQ-027: On rst: reg_addr=0, part=0, latch_fnum=0, up_ch=0, ch_din=0, all strobes 0, pending buffer empty, busy=0, counter=0, dout=0.
- REQ-028: rst asserted with a pending update SHALL discard it; no strobe after rst release until a new data write.

Verification
- REQ-029: Write addr0 A4, data 0x2B, addr0 A0, data 0x55 -> latch_fnum=0x2B, then one up_fnumlo pulse with up_ch=0, ch_din=0x55 on a cen cycle.
- REQ-030: addr=2 write B5, addr=3 write 0xC7 -> single up_pms pulse, up_ch=5, ch_din=0xC7; with NUM_CH=3 -> no strobe, busy still set.
- REQ-031: Data write after address 0xA3 or 0x30 -> no strobe; dout=0x80 for BUSY_CYC cen ticks then 0x00.
- REQ-032: cen held low, two data writes B0 (0x11) then B1 (0x22) -> one up_alg pulse only, up_ch=1, ch_din=0x22.
- REQ-033: wr_n held low 10 clks on data port -> exactly one strobe, busy loaded once.
- REQ-034: rst pulsed between data write and next cen -> no strobe, all outputs 0, latch_fnum=0.
